// File: rtl/data_memory_responder.sv
// Responder end of the DataMemory link: word RAM with fixed read latency, reads stall the master.
// DataMemory.slave fields map to m_data_* ports. Optional write forwarding: DMEM_WRITE_FORWARD_EN.
module data_memory_responder #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m_data_en,
  input  logic        m_data_we,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wd,
  output logic [31:0] m_data_rd,
  output logic        m_data_stall
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem [DEPTH];

  logic          in_range;
  logic [AW-1:0] index;
  logic          rd_req;
  logic          wr_req;
  logic          fwd_hit;
  logic [31:0]   fwd_rd;

  assign in_range = (m_data_addr < 32'(DEPTH));
  assign index    = m_data_addr[AW-1:0];
  assign rd_req   = m_data_en && !m_data_we && (state_q == S_IDLE);
  assign wr_req   = m_data_en && m_data_we && (state_q == S_IDLE);

`ifdef DMEM_WRITE_FORWARD_EN
  logic          fwd_valid_q, fwd_valid_d;
  logic [AW-1:0] fwd_idx_q, fwd_idx_d;
  logic [31:0]   fwd_data_q, fwd_data_d;

  // Entry tracks the most recent in-range write; only reset clears it.
  always_comb begin
    fwd_valid_d = fwd_valid_q;
    fwd_idx_d   = fwd_idx_q;
    fwd_data_d  = fwd_data_q;
    if (wr_req && in_range) begin
      fwd_valid_d = 1'b1;
      fwd_idx_d   = index;
      fwd_data_d  = m_data_wd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_idx_q   <= fwd_idx_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign fwd_hit = rd_req && fwd_valid_q && in_range && (index == fwd_idx_q);
  assign fwd_rd  = fwd_data_q;
`else
  assign fwd_hit = 1'b0;
  assign fwd_rd  = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req && !fwd_hit) begin
          rdata_d = in_range ? mem[index] : 32'd0;
          cnt_d   = 4'(READ_LATENCY - 1);
          state_d = (READ_LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      // The issue cycle already counted as one stall, so leave WAIT once the count hits 1.
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset; out-of-range writes are dropped.
  always_ff @(posedge clock) begin
    if (wr_req && in_range && !reset) begin
      mem[index] <= m_data_wd;
    end
  end

  // Outputs are gated by reset so an asserted reset silences a held read request at once.
  always_comb begin
    m_data_stall = 1'b0;
    m_data_rd    = 32'd0;
    if (!reset) begin
      if (state_q == S_WAIT) begin
        m_data_stall = 1'b1;
      end else if (state_q == S_RESP) begin
        m_data_rd = rdata_q;
      end else if (rd_req) begin
        if (fwd_hit) begin
          m_data_rd = fwd_rd;
        end else begin
          m_data_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: driver pushes expected read responses, monitor pops and compares.
module tb_data_memory_responder;

  localparam int DEPTH = 1024;
  localparam int RL    = 2;
`ifdef DMEM_WRITE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        stall;

  data_memory_responder #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clock        (clock),
    .reset        (reset),
    .m_data_en    (en),
    .m_data_we    (we),
    .m_data_addr  (addr),
    .m_data_wd    (wd),
    .m_data_rd    (rd),
    .m_data_stall (stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          stalls;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          fails = 0;
  bit          mon_on = 1'b0;
  int          stall_cnt = 0;

  // reference model: word store, forwarding entry, list of written addresses
  logic [31:0] mdl [int];
  int          wlist[$];
  bit          fv = 1'b0;
  int          fa = 0;
  logic [31:0] fd = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!mon_on || reset) begin
      stall_cnt = 0;
    end else if (en && !we) begin
      if (stall) begin
        stall_cnt++;
        check("rd_during_stall", rd, 32'd0);
      end else begin
        if (q.size() == 0) begin
          check("unexpected_response", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check({e.name, "_rd"}, rd, e.data);
          check({e.name, "_stall_cycles"}, 32'(stall_cnt), 32'(e.stalls));
        end
        stall_cnt = 0;
      end
    end else begin
      check("stall_no_read", {31'd0, stall}, 32'd0);
      check("rd_no_read", rd, 32'd0);
      stall_cnt = 0;
    end
  end

  task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d, input string nm);
    int n;
    if (w) begin
      if (a < DEPTH) begin
        mdl[int'(a)] = d;
        wlist.push_back(int'(a));
        fv = 1'b1;
        fa = int'(a);
        fd = d;
      end
    end else begin
      exp_t e;
      bit   hit;
      hit = FWD && fv && (a < DEPTH) && (fa == int'(a));
      e.name   = nm;
      e.stalls = hit ? 0 : RL;
      e.data   = hit ? fd : ((a < DEPTH) ? mdl[int'(a)] : 32'd0);
      q.push_back(e);
    end
    en   = 1'b1;
    we   = w;
    addr = a;
    wd   = d;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (stall && n < 50);
    if (n >= 50) check({nm, "_timeout"}, 32'd1, 32'd0);
    @(posedge clock);
    #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    #12;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_rd", rd, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    mon_on = 1'b1;

    // basic write then read
    req(1, 32'd5, 32'hDEADBEEF, "t1_wr");
    req(0, 32'd5, 32'h0, "t1_rd5");
    idle(1);

    // range boundary
    req(1, 32'h3FF, 32'd1, "t2_wr3ff");
    req(1, 32'h400, 32'd7, "t2_wr400");
    req(0, 32'h400, 32'h0, "t2_rd400");
    req(0, 32'h3FF, 32'h0, "t2_rd3ff");
    req(0, 32'hFFFF_FFFF, 32'h0, "t2_rd_top");
    idle(2);

    // back-to-back reads
    req(1, 32'd1, 32'h11, "t3_wr1");
    req(1, 32'd2, 32'h22, "t3_wr2");
    req(1, 32'd3, 32'h33, "t3_wr3");
    req(0, 32'd1, 32'h0, "t3_rd1");
    req(0, 32'd2, 32'h0, "t3_rd2");
    req(0, 32'd3, 32'h0, "t3_rd3");
    req(0, 32'd3, 32'h0, "t3_rd3_again");
    idle(1);

    // write then immediate read of same word
    req(1, 32'd8, 32'h1, "t6_wr8");
    req(0, 32'd8, 32'h0, "t6_rd8");
    req(0, 32'd5, 32'h0, "t6_rd5");
    idle(1);

    // async reset in the middle of a read
    mon_on = 1'b0;
    en = 1'b1; we = 1'b0; addr = 32'd5;
    @(posedge clock);
    #1;
    check("pre_reset_stall", {31'd0, stall}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_stall", {31'd0, stall}, 32'd0);
    check("async_reset_rd", rd, 32'd0);
    en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    fv = 1'b0;
    @(posedge clock);
    #1;
    mon_on = 1'b1;
    req(0, 32'd5, 32'h0, "t5_rd5_after_reset");
    req(0, 32'd8, 32'h0, "t5_rd8_after_reset");
    idle(1);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 4) begin
        if ($urandom_range(0, 9) == 0) a = 32'(DEPTH) + $urandom_range(0, 300);
        else a = $urandom_range(0, DEPTH - 1);
        req(1, a, $urandom, "rnd_wr");
      end else begin
        if ($urandom_range(0, 7) == 0) a = 32'(DEPTH) + $urandom_range(0, 300);
        else a = 32'(wlist[$urandom_range(0, wlist.size() - 1)]);
        req(0, a, 32'h0, "rnd_rd");
        if ($urandom_range(0, 4) == 0) req(0, a, 32'h0, "rnd_rd_repeat");
      end
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
